axi_wr_rr_arbiter: RTL and testbench
====================================

AXI_WR_RR_ARBITER -- requirements
Module: axi_wr_rr_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4, gives the number of requesting masters; the block SHALL support values 1..16.
REQ-002 Parameter IDX_W, default 2, gives the index width; it SHALL equal max(1, clog2(NUM_MASTERS)).
REQ-003 Clocking and reset SHALL be exactly as follows: one clock (ACLK); reset ARESET, synchronous, active-high.
REQ-004 ACLK  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 ARESET  in  1  synchronous active-high reset.
REQ-006 M_AWVALID  in  NUM_MASTERS  per-master write-address valid.
REQ-007 S_AWREADY  in  1  downstream slave write-address ready.
REQ-008 M_WVALID  in  NUM_MASTERS  per-master write-data valid.
REQ-009 M_WLAST  in  NUM_MASTERS  per-master write-data last beat.
REQ-010 S_WREADY  in  1  downstream slave write-data ready.
REQ-011 Grant  out  NUM_MASTERS  one-hot registered grant, all zero when idle.
REQ-012 Grant_Idx  out  IDX_W  binary index of the granted master.
REQ-013 AW_Sel_Valid  out  1  AWVALID of the granted master, forwarded to the slave.
REQ-014 W_Sel_Active  out  1  high while the W channel is routed to the granted master.
REQ-015 Busy  out  1  high whenever the block is not in state IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ADDR and DATA.
REQ-017 IDLE: if any M_AWVALID bit is 1, the block SHALL select one master round-robin, starting at pointer Ptr and searching upward with wrap-around.
  - On a selection, Grant and Grant_Idx SHALL be registered and the FSM SHALL go to ADDR on the next edge.
  - If no M_AWVALID bit is set, the FSM SHALL remain in IDLE.
REQ-018 Latency: M_AWVALID high at edge t SHALL give Grant valid after edge t+1; the minimum request-to-grant latency is one cycle.
REQ-019 ADDR: AW_Sel_Valid SHALL equal M_AWVALID[Grant_Idx] combinationally.
  - When M_AWVALID[Grant_Idx] and S_AWREADY are both 1, the FSM SHALL go to DATA.
  - Otherwise the FSM SHALL stay in ADDR with Grant held, including when the master deasserts AWVALID.
REQ-020 AW_Sel_Valid SHALL be 0 in IDLE and DATA.
REQ-021 DATA: W_Sel_Active SHALL be 1. When M_WVALID[Grant_Idx], M_WLAST[Grant_Idx] and S_WREADY are all 1, the block SHALL:
  - go to IDLE;
  - clear Grant to all zero;
  - set Ptr to (Grant_Idx+1) mod NUM_MASTERS.
REQ-022 Non-last W beats SHALL NOT change state. Inputs from non-granted masters SHALL be ignored in ADDR and DATA.
REQ-023 Grant SHALL never change while in ADDR or DATA, and at most one Grant bit SHALL ever be 1.
REQ-024 Last-beat handshake with other masters pending: the FSM SHALL pass through IDLE for one cycle (one bubble) and re-arbitrate there using the updated Ptr.
REQ-025 With NUM_MASTERS=1, Ptr SHALL stay 0 and Grant_Idx SHALL stay 0.
REQ-026 A request from a master that is not selected SHALL be served within NUM_MASTERS-1 completed bursts, provided its AWVALID remains high.
REQ-027 Ptr SHALL be updated only on completion of a last-beat W handshake.

Reset
REQ-028 When ARESET=1 at a clock edge, the block SHALL:
  - set the FSM to IDLE and Ptr to 0;
  - set Grant=0 and Grant_Idx=0;
  - drive AW_Sel_Valid=0, W_Sel_Active=0 and Busy=0 from that edge.
REQ-029 Reset asserted in ADDR or DATA SHALL abandon the burst with no completion and no Ptr update.
REQ-030 After release, master 0 SHALL hold the highest priority.

Verification (NUM_MASTERS=4)
REQ-031 Single master: M_AWVALID=4'b0100 -> next cycle Grant=4'b0100, Grant_Idx=2, Busy=1; with S_AWREADY=1 -> DATA; 3 W beats, last with S_WREADY=1 -> IDLE, Ptr=3.
REQ-032 Fairness: M_AWVALID=4'b1111 held, each master doing 1-beat bursts -> grant order 0,1,2,3,0, one IDLE cycle between bursts.
REQ-033 Wrap-around: Ptr=3 with M_AWVALID=4'b0011 -> Grant_Idx=0, and the following grant goes to master 1.
REQ-034 Backpressure: in ADDR with S_AWREADY=0 for 5 cycles -> AW_Sel_Valid=1 and Grant constant throughout; in DATA with S_WREADY=0 and WLAST=1 -> remains in DATA.
REQ-035 Reset mid-burst: ARESET=1 during DATA with Grant=4'b0010 -> next cycle Grant=0, W_Sel_Active=0, Busy=0; after release with 4'b0011 requested -> master 0 granted.
REQ-036 Isolation: in DATA for master 1, M_WLAST[3]=M_WVALID[3]=1 with S_WREADY=1 -> no state change.

Source files
------------

// File: rtl/axi_wr_rr_arbiter_if.sv
// Write-channel arbitration bus: per-master AW/W controls in, grant/status out.
interface axi_wr_rr_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2
);
    logic [NUM_MASTERS-1:0] M_AWVALID;
    logic                   S_AWREADY;
    logic [NUM_MASTERS-1:0] M_WVALID;
    logic [NUM_MASTERS-1:0] M_WLAST;
    logic                   S_WREADY;
    logic [NUM_MASTERS-1:0] Grant;
    logic [IDX_W-1:0]       Grant_Idx;
    logic                   AW_Sel_Valid;
    logic                   W_Sel_Active;
    logic                   Busy;

    // Arbiter side
    modport slave (
        input  M_AWVALID, S_AWREADY, M_WVALID, M_WLAST, S_WREADY,
        output Grant, Grant_Idx, AW_Sel_Valid, W_Sel_Active, Busy
    );

    // Requester / observer side
    modport master (
        output M_AWVALID, S_AWREADY, M_WVALID, M_WLAST, S_WREADY,
        input  Grant, Grant_Idx, AW_Sel_Valid, W_Sel_Active, Busy
    );
endinterface

// File: rtl/axi_wr_rr_arbiter.sv
// Round-robin write arbiter: owns one master from AW handshake through its
// W last beat, then releases and advances the priority pointer.
module axi_wr_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2
) (
    input  logic              ACLK,
    input  logic              ARESET,
    axi_wr_rr_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       grant_idx;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       sel_idx;
    logic                   any_req;
    logic                   aw_hs;
    logic                   w_last_hs;
    logic [2*NUM_MASTERS-1:0] req_rot;

    assign any_req   = |bus.M_AWVALID;
    assign aw_hs     = bus.M_AWVALID[grant_idx] & bus.S_AWREADY;
    assign w_last_hs = bus.M_WVALID[grant_idx] & bus.M_WLAST[grant_idx] & bus.S_WREADY;

    // Rotate requests so the pointer sits at bit 0; first set bit wins.
    assign req_rot = {bus.M_AWVALID, bus.M_AWVALID} >> ptr;

    // Round-robin pick: first requester at or above ptr, wrapping.
    always_comb begin
        logic found;
        found   = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && req_rot[k]) begin
                found   = 1'b1;
                sel_idx = IDX_W'((int'(ptr) + k) % NUM_MASTERS);
            end
        end
    end

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: IDLE -> ADDR on any request, ADDR -> DATA on AW handshake,
    // DATA -> IDLE on the granted master's last W beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)   state_nxt = ADDR;
            ADDR:    if (aw_hs)     state_nxt = DATA;
            DATA:    if (w_last_hs) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the registered state
    always_comb begin
        bus.AW_Sel_Valid = 1'b0;
        bus.W_Sel_Active = 1'b0;
        bus.Busy         = (state != IDLE);
        case (state)
            ADDR:    bus.AW_Sel_Valid = bus.M_AWVALID[grant_idx];
            DATA:    bus.W_Sel_Active = 1'b1;
            default: ;
        endcase
    end

    // Grant and pointer: latched at arbitration, frozen through the burst,
    // released (and ptr advanced) only on the last-beat handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            grant     <= '0;
            grant_idx <= '0;
            ptr       <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    grant     <= NUM_MASTERS'(1) << sel_idx;
                    grant_idx <= sel_idx;
                end
                DATA: if (w_last_hs) begin
                    grant <= '0;
                    ptr   <= (grant_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Grant     = grant;
    assign bus.Grant_Idx = grant_idx;

endmodule

// File: tb/tb_axi_wr_rr_arbiter.sv
// Directed bench: stimulus pushes expected grant indices into a queue, a
// monitor pops one each time a new grant appears and checks it.
module tb_axi_wr_rr_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    logic ACLK = 1'b0;
    logic ARESET;

    axi_wr_rr_arbiter_if #(.NUM_MASTERS(N), .IDX_W(W)) bus ();

    axi_wr_rr_arbiter #(.NUM_MASTERS(N), .IDX_W(W)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus.slave)
    );

    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    logic [N-1:0] prev_grant = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each fresh grant is compared against the next expected index
    always @(negedge ACLK) begin
        if (!ARESET && bus.Grant != '0 && prev_grant == '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", {28'd0, bus.Grant}, 32'd0);
            end else begin
                int e;
                logic [N-1:0] one;
                e   = exp_q.pop_front();
                one = 4'b0001;
                check("grant_idx", {30'd0, bus.Grant_Idx}, e);
                check("grant_onehot", {28'd0, bus.Grant}, {28'd0, one << e});
            end
        end
        prev_grant <= bus.Grant;
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wait_busy();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.Busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) check("wait_busy_timeout", 32'd0, 32'd1);
    endtask

    // Caller is in ADDR for master idx: AW handshake, then `beats` W beats
    task automatic burst(input int idx, input int beats, input bit drop_aw);
        logic [N-1:0] m;
        m = 4'b0001;
        m = m << idx;
        bus.S_AWREADY = 1'b1;
        step();
        bus.S_AWREADY = 1'b0;
        if (drop_aw) bus.M_AWVALID = bus.M_AWVALID & ~m;
        check("aw_to_data", {31'd0, bus.W_Sel_Active}, 32'd1);
        for (int b = 1; b <= beats; b++) begin
            bus.M_WVALID = m;
            bus.M_WLAST  = (b == beats) ? m : '0;
            bus.S_WREADY = 1'b1;
            step();
            if (b < beats) check("data_hold", {31'd0, bus.W_Sel_Active}, 32'd1);
        end
        bus.M_WVALID = '0;
        bus.M_WLAST  = '0;
        bus.S_WREADY = 1'b0;
        check("burst_done_busy", {31'd0, bus.Busy}, 32'd0);
        check("burst_done_grant", {28'd0, bus.Grant}, 32'd0);
    endtask

    initial begin
        ARESET        = 1'b1;
        bus.M_AWVALID = '0;
        bus.S_AWREADY = 1'b0;
        bus.M_WVALID  = '0;
        bus.M_WLAST   = '0;
        bus.S_WREADY  = 1'b0;
        step();
        step();

        // Reset state
        check("rst_grant", {28'd0, bus.Grant}, 32'd0);
        check("rst_idx", {30'd0, bus.Grant_Idx}, 32'd0);
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_awsel", {31'd0, bus.AW_Sel_Valid}, 32'd0);
        check("rst_wact", {31'd0, bus.W_Sel_Active}, 32'd0);
        ARESET = 1'b0;

        // Single master 2, three beats; leaves ptr at 3
        exp_q.push_back(2);
        bus.M_AWVALID = 4'b0100;
        step();
        check("single_busy", {31'd0, bus.Busy}, 32'd1);
        check("single_awsel", {31'd0, bus.AW_Sel_Valid}, 32'd1);
        check("single_wact", {31'd0, bus.W_Sel_Active}, 32'd0);
        burst(2, 3, 1'b1);

        // Wrap-around from ptr=3: master 0 first, then master 1
        exp_q.push_back(0);
        exp_q.push_back(1);
        bus.M_AWVALID = 4'b0011;
        wait_busy();
        burst(0, 1, 1'b1);
        check("wrap_bubble", {31'd0, bus.Busy}, 32'd0);
        wait_busy();

        // ADDR backpressure on master 1
        for (int i = 0; i < 5; i++) begin
            check("aw_bp_awsel", {31'd0, bus.AW_Sel_Valid}, 32'd1);
            check("aw_bp_grant", {28'd0, bus.Grant}, 32'h2);
            step();
        end
        bus.M_AWVALID = 4'b0000;
        step();
        check("aw_drop_busy", {31'd0, bus.Busy}, 32'd1);
        check("aw_drop_grant", {28'd0, bus.Grant}, 32'h2);
        check("aw_drop_awsel", {31'd0, bus.AW_Sel_Valid}, 32'd0);
        bus.M_AWVALID = 4'b0010;
        bus.S_AWREADY = 1'b1;
        step();
        bus.S_AWREADY = 1'b0;
        bus.M_AWVALID = 4'b0000;
        check("m1_data", {31'd0, bus.W_Sel_Active}, 32'd1);

        // Isolation: last beat from non-granted master 3
        bus.M_WVALID = 4'b1000;
        bus.M_WLAST  = 4'b1000;
        bus.S_WREADY = 1'b1;
        step();
        check("iso_wact", {31'd0, bus.W_Sel_Active}, 32'd1);
        check("iso_grant", {28'd0, bus.Grant}, 32'h2);

        // W backpressure with WLAST held
        bus.M_WVALID = 4'b0010;
        bus.M_WLAST  = 4'b0010;
        bus.S_WREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("w_bp_wact", {31'd0, bus.W_Sel_Active}, 32'd1);
        end

        // Reset mid-burst abandons it; master 0 has priority afterwards
        ARESET = 1'b1;
        step();
        check("mid_rst_grant", {28'd0, bus.Grant}, 32'd0);
        check("mid_rst_wact", {31'd0, bus.W_Sel_Active}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("mid_rst_idx", {30'd0, bus.Grant_Idx}, 32'd0);
        ARESET       = 1'b0;
        bus.M_WVALID = '0;
        bus.M_WLAST  = '0;
        exp_q.push_back(0);
        exp_q.push_back(1);
        bus.M_AWVALID = 4'b0011;
        wait_busy();
        burst(0, 1, 1'b1);
        wait_busy();
        burst(1, 1, 1'b1);

        // Fairness from a fresh reset: all request, order 0,1,2,3,0
        ARESET = 1'b1;
        step();
        step();
        ARESET = 1'b0;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(0);
        bus.M_AWVALID = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_busy();
            burst(k % N, 1, 1'b0);
        end
        bus.M_AWVALID = 4'b0000;
        step();
        step();
        step();
        check("idle_end", {31'd0, bus.Busy}, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

endmodule
